// File: rtl/updown_counter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// updown_counter: loadable modulo-MODULUS up/down counter with terminal count,
// one-cycle wrap pulse and sticky wrapped flag.                   Rev 1.0
// -----------------------------------------------------------------------------
module updown_counter #(
  parameter int WIDTH   = 8,
  parameter int MODULUS = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             wrapped
);

  // MODULUS-1 always fits in WIDTH bits because MODULUS <= 2**WIDTH.
  localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

  generate
    if (MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_modulus
      $error("updown_counter: MODULUS must lie in 2..2**WIDTH");
    end
  endgenerate

  logic             at_max;
  logic             at_zero;
  logic             at_end;
  logic [WIDTH-1:0] load_clamped;

  assign at_max       = (count == MAX_COUNT);
  assign at_zero      = (count == '0);
  assign at_end       = up ? at_max : at_zero;
  assign load_clamped = (load_value > MAX_COUNT) ? MAX_COUNT : load_value;
  assign tc           = en & at_end;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count   <= '0;
      wrap    <= 1'b0;
      wrapped <= 1'b0;
    end else if (clear) begin
      count   <= '0;
      wrap    <= 1'b0;
      wrapped <= 1'b0;
    end else if (load) begin
      count <= load_clamped;
      wrap  <= 1'b0;
    end else if (en) begin
      if (at_end) begin
        count   <= up ? '0 : MAX_COUNT;
        wrap    <= 1'b1;
        wrapped <= 1'b1;
      end else begin
        count <= up ? (count + ONE) : (count - ONE);
        wrap  <= 1'b0;
      end
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule
`default_nettype wire
